// File: rtl/serial_word_tx.sv
// CPU serial output back end: buffers 16-bit words in a small FIFO and sends each
// one on the TX line as two 8N1 bytes, low byte first.
module serial_word_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SerialWrite,
  input  logic [15:0] SerialData,
  output logic        TxD,
  output logic        Full,
  output logic        Empty,
  output logic        Dropped
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              dropped_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [15:0]       head;

  state_t            state_q;
  logic              byte_sel_q;
  logic [2:0]        bit_idx_q;
  logic [CNT_W-1:0]  baud_q;
  logic [15:0]       word_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              baud_last;

  assign full      = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = SerialWrite & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign head      = mem_q[rd_ptr_q];
  assign baud_last = (baud_q == BAUD_LAST);

  assign Full    = full;
  assign Empty   = empty;
  assign Dropped = dropped_q;
  assign TxD     = tx_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; only the pointers and count define its contents.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= SerialData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      dropped_q <= SerialWrite & full;
    end
  end

  // The line register follows the current state, so TxD trails the state by one
  // cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            word_q     <= head;
            shift_q    <= head[7:0];
            byte_sel_q <= 1'b0;
            baud_q     <= '0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (baud_last) begin
            baud_q    <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            baud_q <= '0;
            if (!byte_sel_q) begin
              shift_q    <= word_q[15:8];
              byte_sel_q <= 1'b1;
              state_q    <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: a UART line monitor decodes words and checks them
// against an expected queue filled as words are pushed.
module tb_serial_word_tx;

  localparam int CPB = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        wr1 = 1'b0;
  logic        wr2 = 1'b0;
  logic [15:0] data = '0;
  logic        txd1, full1, empty1, drop1;
  logic        txd2, full2, empty2, drop2;

  serial_word_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(3)) u_dut (
    .Clock(Clock), .Reset(Reset), .SerialWrite(wr1), .SerialData(data),
    .TxD(txd1), .Full(full1), .Empty(empty1), .Dropped(drop1)
  );

  serial_word_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(1)) u_dut_small (
    .Clock(Clock), .Reset(Reset), .SerialWrite(wr2), .SerialData(data),
    .TxD(txd2), .Full(full2), .Empty(empty2), .Dropped(drop2)
  );

  always #5 Clock = ~Clock;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        sel2 = 1'b0;

  // Line monitor state
  int          mcyc = 0;
  int          rx_words = 0;
  int          wstart[$];
  int          wend_last = 0;
  logic        in_frame = 1'b0;
  logic        half = 1'b0;
  logic        prev = 1'b1;
  logic        line;
  logic        cur;
  logic        width_bad;
  int          pos;
  int          bstart;
  int          cur_wstart;
  logic [9:0]  bits;
  logic [7:0]  low_b;
  logic [15:0] rx_word;
  logic [15:0] exp_w;

  always @(negedge Clock) begin
    line = sel2 ? txd2 : txd1;
    mcyc++;
    if (Reset) begin
      in_frame = 1'b0;
      half     = 1'b0;
      prev     = 1'b1;
    end else begin
      if (!in_frame && prev === 1'b1 && line === 1'b0) begin
        in_frame  = 1'b1;
        pos       = 0;
        bstart    = mcyc;
        width_bad = 1'b0;
      end
      if (in_frame) begin
        if (pos % CPB == 0) cur = line;
        else if (line !== cur) width_bad = 1'b1;
        if (pos % CPB == CPB - 1) bits[pos / CPB] = cur;
        pos++;
        if (pos == 10 * CPB) begin
          in_frame = 1'b0;
          checks++;
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || width_bad) begin
            errors++;
            $display("FAIL framing at cycle %0d: start %b stop %b width_bad %b, need start 0 stop 1 width_bad 0",
                     bstart, bits[0], bits[9], width_bad);
          end
          if (!half) begin
            low_b      = bits[8:1];
            half       = 1'b1;
            cur_wstart = bstart;
          end else begin
            half    = 1'b0;
            rx_word = {bits[8:1], low_b};
            rx_words++;
            wstart.push_back(cur_wstart);
            wend_last = mcyc;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rx_word unexpected word got %h, none expected", rx_word);
            end else begin
              exp_w = exp_q.pop_front();
              if (rx_word !== exp_w) begin
                errors++;
                $display("FAIL rx_word got %h exp %h", rx_word, exp_w);
              end
            end
          end
        end
      end
      prev = line;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    wr1   = 1'b0;
    wr2   = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push1(input logic [15:0] d, input bit accept);
    data = d;
    wr1  = 1'b1;
    if (accept) exp_q.push_back(d);
    tick();
    wr1 = 1'b0;
  endtask

  task automatic wait_words(input int n, input int bound);
    int k;
    k = 0;
    while (rx_words < n && k < bound) begin
      tick();
      k++;
    end
    checks++;
    if (rx_words < n) begin
      errors++;
      $display("FAIL wait_words timeout got %0d words exp %0d", rx_words, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({txd1, empty1, full1, drop1} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got txd/empty/full/dropped %b exp 1100",
                 i, {txd1, empty1, full1, drop1});
      end
    end
  endtask

  task automatic test_single();
    int base;
    do_reset();
    base = rx_words;
    push1(16'hA55A, 1'b1);
    checks++;
    if (empty1 !== 1'b0 || txd1 !== 1'b1) begin
      errors++;
      $display("FAIL after_push empty %b txd %b exp 0 1", empty1, txd1);
    end
    tick();
    checks++;
    if (empty1 !== 1'b1 || txd1 !== 1'b1) begin
      errors++;
      $display("FAIL after_pop empty %b txd %b exp 1 1", empty1, txd1);
    end
    tick();
    checks++;
    if (txd1 !== 1'b0) begin
      errors++;
      $display("FAIL start_fall txd %b exp 0", txd1);
    end
    wait_words(base + 1, 200);
    checks++;
    if (wend_last - wstart[wstart.size() - 1] + 1 != 20 * CPB) begin
      errors++;
      $display("FAIL frame_len got %0d exp %0d", wend_last - wstart[wstart.size() - 1] + 1, 20 * CPB);
    end
    tick();
    checks++;
    if (empty1 !== 1'b1 || txd1 !== 1'b1) begin
      errors++;
      $display("FAIL single_end empty %b txd %b exp 1 1", empty1, txd1);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int nb;
    do_reset();
    base = rx_words;
    nb   = wstart.size();
    push1(16'h0001, 1'b1);
    push1(16'h0002, 1'b1);
    push1(16'h0003, 1'b1);
    wait_words(base + 3, 400);
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (wstart[nb + i] - wstart[nb + i - 1] != 20 * CPB + 1) begin
        errors++;
        $display("FAIL word_gap %0d got %0d exp %0d", i, wstart[nb + i] - wstart[nb + i - 1], 20 * CPB + 1);
      end
    end
    checks++;
    if (exp_q.size() != 0 || empty1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain pending %0d empty %b exp 0 1", exp_q.size(), empty1);
    end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    base = rx_words;
    for (int i = 0; i < 10; i++) begin
      push1(16'h1000 + 16'(i), i < 9);
      checks++;
      if (full1 !== (i >= 8) || drop1 !== (i == 9)) begin
        errors++;
        $display("FAIL overflow push %0d full %b dropped %b exp %b %b",
                 i, full1, drop1, i >= 8, i == 9);
      end
    end
    tick();
    checks++;
    if (drop1 !== 1'b0) begin
      errors++;
      $display("FAIL dropped_one_cycle got %b exp 0", drop1);
    end
    wait_words(base + 9, 9 * (20 * CPB + 1) + 100);
    checks++;
    if (exp_q.size() != 0 || empty1 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain pending %0d empty %b exp 0 1", exp_q.size(), empty1);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int bad;
    do_reset();
    base = rx_words;
    for (int i = 0; i < 4; i++) push1(16'hB000 + 16'(i), 1'b0);
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (txd1 !== 1'b1 || empty1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid txd %b empty %b exp 1 1", txd1, empty1);
    end
    Reset = 1'b0;
    bad = 0;
    repeat (200) begin
      tick();
      if (txd1 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || rx_words != base || full1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet low_cycles %0d words %0d full %b exp 0 %0d 0", bad, rx_words, full1, base);
    end
  endtask

  task automatic test_small_fifo();
    int base;
    sel2 = 1'b1;
    do_reset();
    base = rx_words;
    for (int i = 1; i <= 3; i++) begin
      data = 16'h2000 + 16'(i);
      wr2  = 1'b1;
      exp_q.push_back(data);
      tick();
    end
    checks++;
    if (full2 !== 1'b1) begin
      errors++;
      $display("FAIL small_full got %b exp 1", full2);
    end
    // The second pop lands on edge 82 after the first push; the write there is dropped.
    for (int k = 3; k <= 85; k++) begin
      data = 16'h2100 + 16'(k);
      wr2  = 1'b1;
      if (k == 83) exp_q.push_back(data);
      tick();
      checks++;
      if (drop2 !== (k != 83) || full2 !== (k != 82)) begin
        errors++;
        $display("FAIL small_edge %0d dropped %b full %b exp %b %b", k, drop2, full2, k != 83, k != 82);
      end
    end
    wr2 = 1'b0;
    wait_words(base + 4, 400);
    checks++;
    if (exp_q.size() != 0 || empty2 !== 1'b1) begin
      errors++;
      $display("FAIL small_drain pending %0d empty %b exp 0 1", exp_q.size(), empty2);
    end
    sel2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_small_fifo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
